counter_reload_ctrl: RTL and testbench
======================================

Name: counter_reload_ctrl

Overview:
- Downstream/feedback control stage for the 8-bit loadable up counter.
- Consumes the counter's count and drives its load/data inputs, so the counter runs as a periodic timer from START up to TOP.
- Produces a PWM output, a period-boundary pulse, and accepts new configurations through a one-entry shadow register.
- New configurations apply only at period boundaries, so a period is never cut short or glitched.

Parameters:
- WIDTH, 8, width of count/config/data paths.
- TOP_RST, 2**WIDTH-1, active TOP value after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low
- en  in  1  run enable
- cfg_valid  in  1  config offer
- cfg_ready  out  1  shadow register empty, config will be accepted
- cfg_top  in  WIDTH  terminal count
- cfg_start  in  WIDTH  reload value
- cfg_cmp  in  WIDTH  PWM compare threshold
- count_in  in  WIDTH  counter's registered count
- load_out  out  1  to counter load (combinational)
- data_out  out  WIDTH  to counter data (combinational)
- pwm_out  out  1  registered PWM
- period_pulse  out  1  one-cycle pulse per reload, registered
- cfg_applied  out  1  one-cycle pulse when shadow is moved to active, registered

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; active top=TOP_RST, start=0, cmp=0.
  - Shadow cleared and any pending config discarded; cfg_ready=1.
  - pwm_out=0, period_pulse=0, cfg_applied=0.
  - Reset overrides every other event, including mid-period.
- Config handshake:
  - Accept occurs when cfg_valid & cfg_ready at an edge; shadow latches top/start/cmp and goes full.
  - cfg_ready = !shadow_full.
  - The shadow empties only on apply.
  - cfg_valid held while cfg_ready=0 is accepted later, with no loss.
- States:
  - IDLE: load_out=0. If en=1, go to ARM at the next edge.
  - ARM (exactly one cycle):
    - load_out=1; data_out = shadow start if the shadow is full, else active start.
    - If the shadow is full, apply it at this edge: copy to active, empty the shadow, cfg_applied=1 in the next cycle.
    - Go to RUN. period_pulse is not asserted.
  - RUN:
    - load_out = (count_in == active top).
    - data_out = shadow start if the shadow is full, else active start. This value is only meaningful while load_out=1, otherwise it is don't-care.
    - On the edge where load_out=1: apply the shadow if full (same rules as ARM), and set period_pulse=1 for the next cycle.
  - Any state with en=0 goes to IDLE at the next edge. pwm_out=0 from the cycle after the en=0 edge. The shadow is retained.
- Apply vs accept in the same cycle:
  - Apply uses shadow contents before the edge.
  - Accept is impossible while the shadow is full.
  - A config accepted at a boundary edge where the shadow was empty takes effect at the next boundary.
- PWM:
  - pwm_out <= (state==RUN) & en & (count_in < active cmp). One-cycle latency relative to count_in.
  - cmp=0: always low.
  - cmp > top (e.g. top=9, cmp=200): high whenever RUN with start ≤ top.
- Period and wrap:
  - Period = ((top - start) mod 2^WIDTH) + 1 cycles.
  - start > top is legal: the counter wraps through 0.
  - start == top gives a 1-cycle period with load_out held high continuously.
  - All comparisons are unsigned, WIDTH bits. No saturation.

Decomposition:
- Shared package counter_pkg:
  - state enum {IDLE, ARM, RUN}.
  - WIDTH default.
  - struct cnt_cfg_t {top, start, cmp}.
- Sub-module cfg_shadow_reg: one-entry valid/ready holding register with a take/apply strobe. It owns cfg_ready and the full flag.
- The FSM, compare logic and PWM stay in the top level.

Test Plan:
- Bench counter model: load has priority over increment, reset to 0.
1. Reset, en=1, no cfg -> ARM cycle has load_out=1, data_out=0; counter runs 0..255; at count 255 load_out=1, data_out=0; period_pulse every 256 cycles; pwm_out stays 0.
2. cfg top=9, start=2, cmp=5 before en -> cfg_applied in the cycle after ARM; counts 2..9 repeat; period_pulse every 8 cycles; pwm_out high 3 cycles per period (counts 2,3,4, delayed 1 cycle).
3. Running top=9, then offer two configs back-to-back -> first accepted, cfg_ready=0 until the next count==9 edge; second accepted after that edge and applied at the following boundary; no period shortened.
4. top=3, start=250 -> sequence 250..255,0..3, period 10 cycles; load_out only at count 3.
5. en dropped mid-period at count 5 -> next cycle IDLE, load_out=0, pwm_out=0; re-raise en -> ARM load of active start.
6. rst=0 with a pending shadow mid-RUN -> next cycle cfg_ready=1, pwm_out=0, state IDLE; active top back to 255.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the loadable-counter reload controller.
//   CNT_WIDTH : default width of count/config/data paths
//   state_t   : controller FSM states
//   cnt_cfg_t : one timer configuration (terminal count, reload value, PWM threshold)
package counter_pkg;

    localparam int unsigned CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] top;
        logic [CNT_WIDTH-1:0] start;
        logic [CNT_WIDTH-1:0] cmp;
    } cnt_cfg_t;

endpackage

// File: rtl/cfg_shadow_reg.sv
// One-entry valid/ready holding register for a pending timer configuration.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   cfg_valid  : config offer from the host
//   cfg_ready  : register empty, an offer at this edge is accepted
//   cfg_in     : offered config
//   take       : controller moves the held config to active (only asserted while full)
//   full       : a config is held
//   cfg_out    : held config
module cfg_shadow_reg
    import counter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     cfg_valid,
    output logic     cfg_ready,
    input  cnt_cfg_t cfg_in,
    input  logic     take,
    output logic     full,
    output cnt_cfg_t cfg_out
);

    logic     full_q;
    cnt_cfg_t data_q;

    assign cfg_ready = !full_q;
    assign full      = full_q;
    assign cfg_out   = data_q;

    // Accept needs empty and take needs full, so the two never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (cfg_valid && !full_q) begin
            full_q <= 1'b1;
            data_q <= cfg_in;
        end else if (take) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_reload_ctrl.sv
// Feedback controller that turns an external loadable up counter into a periodic
// timer running START..TOP, with PWM output and boundary-synchronous reconfiguration.
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   en             : run enable
//   cfg_valid/ready: config handshake into the shadow register
//   cfg_top/start/cmp : offered terminal count, reload value, PWM threshold
//   count_in       : counter's registered count
//   load_out, data_out : counter load strobe and reload value (combinational)
//   pwm_out        : registered PWM, high while count < cmp in RUN
//   period_pulse   : one-cycle pulse after each reload in RUN
//   cfg_applied    : one-cycle pulse after the shadow config becomes active
module counter_reload_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = CNT_WIDTH,  // must match CNT_WIDTH
    parameter logic [WIDTH-1:0] TOP_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_top,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_cmp,
    input  logic [WIDTH-1:0] count_in,
    output logic             load_out,
    output logic [WIDTH-1:0] data_out,
    output logic             pwm_out,
    output logic             period_pulse,
    output logic             cfg_applied
);

    localparam cnt_cfg_t RST_CFG = '{top: TOP_RST, start: '0, cmp: '0};

    state_t   state_q, state_d;
    cnt_cfg_t active_q;
    cnt_cfg_t cfg_in;
    cnt_cfg_t shadow_cfg;
    logic     shadow_full;
    logic     take;
    logic     pwm_q, period_q, applied_q;

    assign cfg_in = '{top: cfg_top, start: cfg_start, cmp: cfg_cmp};

    cfg_shadow_reg u_shadow (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_in    (cfg_in),
        .take      (take),
        .full      (shadow_full),
        .cfg_out   (shadow_cfg)
    );

    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = ARM;
            ARM: begin
                load_out = 1'b1;
                state_d  = RUN;
            end
            RUN:     load_out = (count_in == active_q.top);
            default: state_d = IDLE;
        endcase
        if (!en) state_d = IDLE;
    end

    // A pending config supplies the reload value of the very load that applies it,
    // so the new period starts at the new START.
    assign data_out = shadow_full ? shadow_cfg.start : active_q.start;
    assign take     = load_out && shadow_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            active_q  <= RST_CFG;
            pwm_q     <= 1'b0;
            period_q  <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (take) active_q <= shadow_cfg;
            pwm_q     <= (state_q == RUN) && en && (count_in < active_q.cmp);
            period_q  <= (state_q == RUN) && load_out;
            applied_q <= take;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_pulse = period_q;
    assign cfg_applied  = applied_q;

endmodule

// File: tb/tb_counter_reload_ctrl.sv
module tb_counter_reload_ctrl;

    typedef struct {
        logic [7:0] top;
        logic [7:0] start;
        logic [7:0] cmp;
    } mcfg_t;

    typedef struct {
        logic [7:0] cnt;
        logic       load;
        logic [7:0] data;
        logic       ready;
        logic       pwm;
        logic       pulse;
        logic       app;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_top = 8'd0;
    logic [7:0] cfg_start = 8'd0;
    logic [7:0] cfg_cmp = 8'd0;
    logic [7:0] count_in;
    logic       cfg_ready, load_out, pwm_out, period_pulse, cfg_applied;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail = 0;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    counter_reload_ctrl #(
        .WIDTH   (8),
        .TOP_RST (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_top      (cfg_top),
        .cfg_start    (cfg_start),
        .cfg_cmp      (cfg_cmp),
        .count_in     (count_in),
        .load_out     (load_out),
        .data_out     (data_out),
        .pwm_out      (pwm_out),
        .period_pulse (period_pulse),
        .cfg_applied  (cfg_applied)
    );

    // External counter: reset to 0, load has priority over increment.
    always @(posedge clk) begin
        if (!rst)          count_in <= 8'd0;
        else if (load_out) count_in <= data_out;
        else               count_in <= count_in + 8'd1;
    end

    // Reference model: a timer described by period length, not by the counter compare.
    bit         m_run, m_arm, m_accepted;
    int         m_left;
    mcfg_t      m_act;
    mcfg_t      m_sh[$];
    logic       m_pwm, m_pulse, m_app;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_run   = 1'b0;
        m_arm   = 1'b0;
        m_left  = 0;
        m_act   = '{8'hFF, 8'd0, 8'd0};
        m_sh.delete();
        m_pwm   = 1'b0;
        m_pulse = 1'b0;
        m_app   = 1'b0;
        m_cnt   = 8'd0;
    endtask

    task automatic model_step(input logic r, input logic e, input logic v, input mcfg_t c);
        exp_t       x;
        logic       ld, rdy;
        logic [7:0] dt;
        rdy = (m_sh.size() == 0);
        ld  = m_arm || (m_run && m_left == 1);
        dt  = rdy ? m_act.start : m_sh[0].start;
        x   = '{m_cnt, ld, dt, rdy, m_pwm, m_pulse, m_app};
        sb_q.push_back(x);
        m_accepted = 1'b0;
        if (!r) begin
            model_reset();
        end else begin
            m_pwm   = m_run && e && (m_cnt < m_act.cmp);
            m_pulse = m_run && (m_left == 1);
            m_app   = ld && !rdy;
            if (m_app) m_act = m_sh.pop_front();
            if (v && rdy) begin
                m_sh.push_back(c);
                m_accepted = 1'b1;
            end
            m_cnt = ld ? dt : m_cnt + 8'd1;
            if (ld) m_left = int'(8'(m_act.top - m_act.start)) + 1;
            else    m_left = m_left - 1;
            if (!e) begin
                m_run = 1'b0;
                m_arm = 1'b0;
            end else if (m_arm) begin
                m_arm = 1'b0;
                m_run = 1'b1;
            end else if (!m_run) begin
                m_arm = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input mcfg_t c);
        @(negedge clk);
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_top   = c.top;
        cfg_start = c.start;
        cfg_cmp   = c.cmp;
        model_step(r, e, v, c);
    endtask

    mcfg_t idle_cfg = '{8'd0, 8'd0, 8'd0};

    task automatic run(input int n, input logic e);
        repeat (n) drive(1'b1, e, 1'b0, idle_cfg);
    endtask

    task automatic offer(input mcfg_t c, input logic e);
        int n = 0;
        do begin
            drive(1'b1, e, 1'b1, c);
            n++;
        end while (!m_accepted && n < 2000);
        if (!m_accepted) begin
            n_checks++;
            n_fail++;
            $display("FAIL offer_timeout: config top=%0d never accepted, required acceptance", c.top);
        end
    endtask

    task automatic run_until_cnt(input logic [7:0] val);
        int n = 0;
        do begin
            drive(1'b1, 1'b1, 1'b0, idle_cfg);
            n++;
        end while (m_cnt != val && n < 2000);
        if (m_cnt != val) begin
            n_checks++;
            n_fail++;
            $display("FAIL count_wait: count %0d not reached, required within 2000 cycles", val);
        end
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output vector; pop and compare.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check("count", count_in, x.cnt);
                check("load_out", 8'(load_out), 8'(x.load));
                if (x.load) check("data_out", data_out, x.data);
                check("cfg_ready", 8'(cfg_ready), 8'(x.ready));
                check("pwm_out", 8'(pwm_out), 8'(x.pwm));
                check("period_pulse", 8'(period_pulse), 8'(x.pulse));
                check("cfg_applied", 8'(cfg_applied), 8'(x.app));
            end
        end
    end

    initial begin
        mcfg_t c;
        logic  r, e, v;
        model_reset();

        // 1: defaults, full 0..255 periods, pwm idle
        drive(1'b0, 1'b0, 1'b0, idle_cfg);
        drive(1'b0, 1'b0, 1'b0, idle_cfg);
        run(600, 1'b1);

        // 2: config loaded while idle, applied at ARM
        drive(1'b0, 1'b0, 1'b0, idle_cfg);
        offer('{8'd9, 8'd2, 8'd5}, 1'b0);
        run(40, 1'b1);

        // 3: two back-to-back offers while running
        offer('{8'd9, 8'd3, 8'd7}, 1'b1);
        offer('{8'd9, 8'd2, 8'd9}, 1'b1);
        run(40, 1'b1);

        // 4: start above top, wrapping through zero
        offer('{8'd3, 8'd250, 8'd252}, 1'b1);
        run(40, 1'b1);

        // 5: enable dropped mid-period, then re-armed
        offer('{8'd20, 8'd0, 8'd10}, 1'b1);
        run(30, 1'b1);
        run_until_cnt(8'd5);
        run(3, 1'b0);
        run(30, 1'b1);

        // 6: reset with a pending shadow mid-run
        offer('{8'd15, 8'd1, 8'd4}, 1'b1);
        run(3, 1'b1);
        offer('{8'd7, 8'd0, 8'd3}, 1'b1);
        drive(1'b0, 1'b1, 1'b0, idle_cfg);
        run(300, 1'b1);

        // Edge cases: 1-cycle period, cmp=0, cmp above top
        offer('{8'd4, 8'd4, 8'd9}, 1'b1);
        run(12, 1'b1);
        offer('{8'd9, 8'd0, 8'd0}, 1'b1);
        run(25, 1'b1);
        offer('{8'd9, 8'd0, 8'd200}, 1'b1);
        run(25, 1'b1);

        // Random traffic
        repeat (3000) begin
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 24) != 0);
            v = ($urandom_range(0, 5) == 0);
            c.top   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 15));
            c.start = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 15));
            c.cmp   = 8'($urandom_range(0, 20));
            drive(r, e, v, c);
        end

        @(negedge clk);
        #5;
        check("scoreboard_drain", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
